// File: rtl/spike_readout.sv
// Reduces the 4-bit node bus over WINDOW samples into a saturating sum and a nonzero count; the optional peak output is enabled by READOUT_PEAK_EN.
// Result is visible the cycle after the last sample; an unaccepted result is overwritten by the next one and flagged with res_ovr.
module spike_readout #(
   parameter  int WINDOW = 16,
   parameter  int ACC_W  = 8,
   localparam int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       in,
   output logic [ACC_W-1:0] res_sum,
   output logic [CNT_W-1:0] res_cnt,
   output logic             res_sat,
   output logic             res_ovr,
   output logic             res_valid,
`ifdef READOUT_PEAK_EN
   output logic [3:0]       res_peak,
`endif
   input  logic             res_ready
);

   localparam int IDX_W = $clog2(WINDOW);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [ACC_W-1:0] acc_sum, sum_n;
   logic [CNT_W-1:0] acc_cnt, cnt_n;
   logic             acc_sat, sat_n;
   logic [ACC_W:0]   sum_wide;
   logic             last;
`ifdef READOUT_PEAK_EN
   logic [3:0]       acc_peak, peak_n;
`endif

   // Next accumulator values including the sample on `in` this cycle.
   always_comb begin
      sum_wide = {1'b0, acc_sum} + {{(ACC_W-3){1'b0}}, in};
      if (sum_wide[ACC_W]) begin
         sum_n = '1;
         sat_n = 1'b1;
      end else begin
         sum_n = sum_wide[ACC_W-1:0];
         sat_n = acc_sat;
      end
      cnt_n = acc_cnt + {{(CNT_W-1){1'b0}}, (in != 4'd0)};
      last  = (idx == IDX_W'(WINDOW - 1));
`ifdef READOUT_PEAK_EN
      peak_n = (in > acc_peak) ? in : acc_peak;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         acc_sum   <= '0;
         acc_cnt   <= '0;
         acc_sat   <= 1'b0;
         res_sum   <= '0;
         res_cnt   <= '0;
         res_sat   <= 1'b0;
         res_ovr   <= 1'b0;
         res_valid <= 1'b0;
`ifdef READOUT_PEAK_EN
         acc_peak  <= '0;
         res_peak  <= '0;
`endif
      end else begin
         // A window-end load below takes priority over this accept.
         if (res_valid && res_ready)
            res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state   <= ACCUM;
                  idx     <= IDX_W'(1);
                  acc_sum <= sum_n;
                  acc_cnt <= cnt_n;
                  acc_sat <= sat_n;
`ifdef READOUT_PEAK_EN
                  acc_peak <= peak_n;
`endif
               end
            end
            ACCUM: begin
               if (!en || last) begin
                  idx     <= '0;
                  acc_sum <= '0;
                  acc_cnt <= '0;
                  acc_sat <= 1'b0;
`ifdef READOUT_PEAK_EN
                  acc_peak <= '0;
`endif
                  if (!en) begin
                     state <= IDLE;
                  end else begin
                     res_sum   <= sum_n;
                     res_cnt   <= cnt_n;
                     res_sat   <= sat_n;
                     res_ovr   <= res_valid && !res_ready;
                     res_valid <= 1'b1;
`ifdef READOUT_PEAK_EN
                     res_peak  <= peak_n;
`endif
                  end
               end else begin
                  idx     <= idx + IDX_W'(1);
                  acc_sum <= sum_n;
                  acc_cnt <= cnt_n;
                  acc_sat <= sat_n;
`ifdef READOUT_PEAK_EN
                  acc_peak <= peak_n;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spike_readout.sv
// Directed bench: a WINDOW=4/ACC_W=8 instance and a WINDOW=4/ACC_W=4 instance share stimulus.
module tb_spike_readout;

   logic       clk = 1'b0;
   logic       rst_n, en, res_ready;
   logic [3:0] din;

   logic [7:0] a_sum;
   logic [2:0] a_cnt;
   logic       a_sat, a_ovr, a_valid;
   logic [3:0] b_sum;
   logic [2:0] b_cnt;
   logic       b_sat, b_ovr, b_valid;
`ifdef READOUT_PEAK_EN
   logic [3:0] a_peak, b_peak;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spike_readout #(.WINDOW(4), .ACC_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in(din),
      .res_sum(a_sum), .res_cnt(a_cnt), .res_sat(a_sat), .res_ovr(a_ovr),
      .res_valid(a_valid),
`ifdef READOUT_PEAK_EN
      .res_peak(a_peak),
`endif
      .res_ready(res_ready)
   );

   spike_readout #(.WINDOW(4), .ACC_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .in(din),
      .res_sum(b_sum), .res_cnt(b_cnt), .res_sat(b_sat), .res_ovr(b_ovr),
      .res_valid(b_valid),
`ifdef READOUT_PEAK_EN
      .res_peak(b_peak),
`endif
      .res_ready(res_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic win4(input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3);
      din = s0; step();
      din = s1; step();
      din = s2; step();
      din = s3; step();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; din = 4'd0; res_ready = 1'b0;
      step(); step();
      check("rst_valid", a_valid, 0);
      check("rst_sum",   a_sum,   0);
      check("rst_cnt",   a_cnt,   0);
      check("rst_sat",   a_sat,   0);
      check("rst_ovr",   a_ovr,   0);

      // Constant 3: one-cycle valid pulse every 4 cycles, first after the 4th sample edge.
      rst_n = 1'b1; en = 1'b1; din = 4'd3; res_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("const_valid", a_valid, (i % 4 == 0) ? 1 : 0);
         if (i % 4 == 0) begin
            check("const_sum", a_sum, 12);
            check("const_cnt", a_cnt, 4);
            check("const_sat", a_sat, 0);
            check("const_ovr", a_ovr, 0);
         end
      end

      win4(4'd0, 4'd5, 4'd0, 4'd15);
      check("mix_valid", a_valid, 1);
      check("mix_sum",   a_sum,   20);
      check("mix_cnt",   a_cnt,   2);
`ifdef READOUT_PEAK_EN
      check("mix_peak",  a_peak,  15);
`endif

      // Saturation on the 4-bit accumulator, then a clean window.
      win4(4'd15, 4'd15, 4'd15, 4'd15);
      check("sat_sum",  b_sum, 15);
      check("sat_flag", b_sat, 1);
      check("sat_cnt",  b_cnt, 4);
      check("wide_sum", a_sum, 60);
      check("wide_sat", a_sat, 0);
      win4(4'd1, 4'd1, 4'd1, 4'd1);
      check("unsat_sum",  b_sum, 4);
      check("unsat_flag", b_sat, 0);

      // Overwrite of an unaccepted result.
      en = 1'b0; step();
      check("drain_valid", a_valid, 0);
      res_ready = 1'b0; en = 1'b1;
      win4(4'd2, 4'd2, 4'd2, 4'd2);
      check("hold1_valid", a_valid, 1);
      check("hold1_sum",   a_sum,   8);
      check("hold1_ovr",   a_ovr,   0);
      win4(4'd1, 4'd1, 4'd1, 4'd1);
      check("ovr_valid", a_valid, 1);
      check("ovr_sum",   a_sum,   4);
      check("ovr_flag",  a_ovr,   1);
      en = 1'b0; res_ready = 1'b1; step();
      check("accept_valid", a_valid, 0);

      // Accept on the exact window-end edge.
      res_ready = 1'b0; en = 1'b1;
      win4(4'd2, 4'd2, 4'd2, 4'd2);
      din = 4'd3; step(); step(); step();
      check("stable_valid", a_valid, 1);
      check("stable_sum",   a_sum,   8);
      res_ready = 1'b1; step();
      check("same_valid", a_valid, 1);
      check("same_sum",   a_sum,   12);
      check("same_ovr",   a_ovr,   0);
      en = 1'b0; step();
      check("same_clear", a_valid, 0);

      // Abort mid-window: aborted samples never reach a result.
      en = 1'b1; din = 4'd7; step(); step();
      en = 1'b0; step();
      check("abort_valid", a_valid, 0);
      en = 1'b1; din = 4'd1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_pend", a_valid, 0);
      end
      step();
      check("abort_res_valid", a_valid, 1);
      check("abort_sum",       a_sum,   4);
      check("abort_cnt",       a_cnt,   4);
`ifdef READOUT_PEAK_EN
      check("abort_peak",      a_peak,  1);
`endif
      en = 1'b0; step();
      check("abort_once", a_valid, 0);

      // Reset mid-window with a result held.
      res_ready = 1'b0; en = 1'b1;
      win4(4'd2, 4'd2, 4'd2, 4'd2);
      check("pre_rst_valid", a_valid, 1);
      din = 4'd5; step(); step();
      rst_n = 1'b0; step();
      check("mid_rst_valid", a_valid, 0);
      check("mid_rst_sum",   a_sum,   0);
      check("mid_rst_cnt",   a_cnt,   0);
      check("mid_rst_sat",   a_sat,   0);
      check("mid_rst_ovr",   a_ovr,   0);
      check("mid_rst_bsum",  b_sum,   0);
`ifdef READOUT_PEAK_EN
      check("mid_rst_peak",  a_peak,  0);
`endif
      rst_n = 1'b1;
      win4(4'd1, 4'd1, 4'd1, 4'd1);
      check("post_rst_valid", a_valid, 1);
      check("post_rst_sum",   a_sum,   4);
      check("post_rst_cnt",   a_cnt,   4);
      check("post_rst_ovr",   a_ovr,   0);
`ifdef READOUT_PEAK_EN
      check("post_rst_peak",  a_peak,  1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
